// File: rtl/score_pkg.sv
// Shared types and constants for the binary-to-BCD score converter.
// digits_needed() sizes the BCD accumulator so no digit can overflow.
package score_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} score_state_t;

  localparam int SCORE_W      = 24;
  localparam int SCORE_DIGITS = 8;

  // Number of decimal digits in the largest value a width-bit unsigned number can hold.
  function automatic int digits_needed(input int width);
    longint unsigned maxVal;
    int n;
    maxVal = (64'd1 << width) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      maxVal = maxVal / 64'd10;
      if (maxVal != 64'd0) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/score_bcd_converter_add3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift,
// so it carries correctly into the next digit once shifted.
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/score_bcd_converter.sv
// Iterative double-dabble converter from binary score to packed BCD digits.
// Outputs hold the last finished result so displayed digits never change mid-conversion.
module score_bcd_converter
  import score_pkg::*;
#(
  parameter int IN_W   = SCORE_W,
  parameter int DIGITS = SCORE_DIGITS
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [IN_W-1:0]       score_in,
  input  logic                  force_conv,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [3:0]            ones,
  output logic [3:0]            tens,
  output logic                  digits_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  if (DIGITS < digits_needed(IN_W)) begin : g_bad_digits
    $error("score_bcd_converter: DIGITS too small to hold 2**IN_W-1");
  end

  score_state_t            state_q;
  logic [IN_W-1:0]         snap_q;
  logic [IN_W-1:0]         lastConv_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        accAdj_d;
  logic [ACC_W+IN_W-1:0]   shift_d;
  logic [ACC_W-1:0]        bcdOut_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    pending_q;
  logic                    digitsValid_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    request_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (accAdj_d[4*g +: 4])
    );
  end

  assign shift_d   = {accAdj_d, snap_q} << 1;
  assign request_d = (score_in != lastConv_q) | pending_q | force_conv;

  // pending_q starts high so a conversion always runs straight out of reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_IDLE;
      snap_q        <= '0;
      lastConv_q    <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      bcdOut_q      <= '0;
      pending_q     <= 1'b1;
      digitsValid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (request_d) begin
            snap_q     <= score_in;
            lastConv_q <= score_in;
            pending_q  <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= CNT_W'(IN_W - 1);
            busy_q     <= 1'b1;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (force_conv) pending_q <= 1'b1;
          {acc_q, snap_q} <= shift_d;
          if (cnt_q == '0) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          if (force_conv) pending_q <= 1'b1;
          bcdOut_q      <= acc_q;
          digitsValid_q <= 1'b1;
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bcd_out      = bcdOut_q;
  assign ones         = bcdOut_q[3:0];
  assign tens         = bcdOut_q[7:4];
  assign digits_valid = digitsValid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: latency, BCD values, restart, reset and force behaviour.
// Expected BCD values are written out by hand from the decimal scores.
module tb_score_bcd_converter;

  logic        Clk;
  logic        Reset_n;
  logic [23:0] scoreIn;
  logic        forceConv;
  logic [31:0] bcdOut;
  logic [3:0]  ones;
  logic [3:0]  tens;
  logic        digitsValid;
  logic        busy;
  logic        done;

  int vectorCount = 0;
  int missCount   = 0;

  score_bcd_converter dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .score_in     (scoreIn),
    .force_conv   (forceConv),
    .bcd_out      (bcdOut),
    .ones         (ones),
    .tens         (tens),
    .digits_valid (digitsValid),
    .busy         (busy),
    .done         (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Follows one conversion whose snapshot edge is the next posedge; checks exact latency.
  task automatic watchConversion(input string tag, input logic [31:0] expBcd);
    for (int i = 1; i <= 26; i++) begin
      @(negedge Clk);
      if (i == 1) checkOutput({tag, "_busy_e1"}, {31'd0, busy}, 32'd1);
      if (i == 25) begin
        checkOutput({tag, "_busy_e25"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_early_done"}, {31'd0, done}, 32'd0);
      end
      if (i == 26) begin
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_bcd"}, bcdOut, expBcd);
        checkOutput({tag, "_valid"}, {31'd0, digitsValid}, 32'd1);
        checkOutput({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [23:0] value, input logic [31:0] expBcd);
    @(negedge Clk);
    scoreIn = value;
    watchConversion(tag, expBcd);
    @(negedge Clk);
    checkOutput({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  task automatic countDone(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int pulses;
    Reset_n   = 1'b0;
    scoreIn   = 24'd0;
    forceConv = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("rst_bcd",   bcdOut, 32'h0);
    checkOutput("rst_valid", {31'd0, digitsValid}, 32'd0);
    checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
    checkOutput("rst_done",  {31'd0, done}, 32'd0);

    // Conversion of zero runs right after reset release.
    Reset_n = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge Clk);
      if (i == 25) checkOutput("init_valid_low", {31'd0, digitsValid}, 32'd0);
    end
    @(negedge Clk);
    checkOutput("init_done",  {31'd0, done}, 32'd1);
    checkOutput("init_valid", {31'd0, digitsValid}, 32'd1);
    checkOutput("init_bcd",   bcdOut, 32'h0);
    @(negedge Clk);
    checkOutput("init_done_drop", {31'd0, done}, 32'd0);
    @(negedge Clk);
    checkOutput("init_idle", {31'd0, busy}, 32'd0);

    applyStimulus("s57", 24'd57, 32'h00000057);
    checkOutput("s57_tens", {28'd0, tens}, 32'd5);
    checkOutput("s57_ones", {28'd0, ones}, 32'd7);
    applyStimulus("smax", 24'hFFFFFF, 32'h16777215);
    applyStimulus("s999", 24'd999, 32'h00000999);
    applyStimulus("s10", 24'd10, 32'h00000010);

    // Score changes mid-shift: old value finishes, new one starts with no idle gap.
    @(negedge Clk);
    scoreIn = 24'd123;
    for (int i = 1; i <= 26; i++) begin
      @(negedge Clk);
      if (i == 11) scoreIn = 24'd456;
      if (i == 26) begin
        checkOutput("chg_done1", {31'd0, done}, 32'd1);
        checkOutput("chg_bcd1",  bcdOut, 32'h00000123);
      end
    end
    watchConversion("chg2", 32'h00000456);
    @(negedge Clk);

    // Asynchronous reset in the middle of a conversion.
    @(negedge Clk);
    scoreIn = 24'd88;
    repeat (10) @(negedge Clk);
    checkOutput("mid_busy", {31'd0, busy}, 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("arst_bcd",   bcdOut, 32'h0);
    checkOutput("arst_busy",  {31'd0, busy}, 32'd0);
    checkOutput("arst_valid", {31'd0, digitsValid}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    watchConversion("rerun", 32'h00000088);
    @(negedge Clk);

    // Held score converts once; force_conv adds exactly one more.
    @(negedge Clk);
    scoreIn = 24'd42;
    countDone(1000, pulses);
    checkOutput("hold_pulses", pulses, 32'd1);
    checkOutput("hold_bcd", bcdOut, 32'h00000042);
    forceConv = 1'b1;
    @(negedge Clk);
    forceConv = 1'b0;
    countDone(40, pulses);
    checkOutput("force_pulses", pulses, 32'd1);
    checkOutput("force_bcd", bcdOut, 32'h00000042);

    // A force during SHIFT is remembered and triggers a second conversion.
    forceConv = 1'b1;
    @(negedge Clk);
    forceConv = 1'b0;
    repeat (5) @(negedge Clk);
    forceConv = 1'b1;
    @(negedge Clk);
    forceConv = 1'b0;
    countDone(80, pulses);
    checkOutput("pend_pulses", pulses, 32'd2);
    checkOutput("pend_bcd", bcdOut, 32'h00000042);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
